// File: rtl/cpu55_bus_arbiter_pkg.sv
// Shared types and constants for the cpu55 external bus arbiter.
package cpu55_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic        RW_WRITE   = 1'b1;
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned STARVE_W   = 4;
  localparam int unsigned TIMER_W    = 10;

endpackage

// File: rtl/cpu55_bus_arbiter_timer.sv
// Bus-wait timeout counter; only instantiated when BUS_ARB_TIMEOUT_EN is defined.
module bus_arb_timer
  import cpu55_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Fires during the TIMEOUT_CYC-th enabled cycle, i.e. the last BUS cycle.
  assign expire = en && (count_q == TIMER_W'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expire) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu55_bus_arbiter.sv
// Fetch/memory-stage arbiter for the single cpu55 bus-controller port.
// Optional bus-wait timeout is enabled with the BUS_ARB_TIMEOUT_EN macro.
module cpu55_bus_arbiter
  import cpu55_bus_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX must be in 1..15");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 2..1023");
  end

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_rw_q, bus_rw_d;
  logic [31:0]         bus_addr_q, bus_addr_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                bus_err_q, bus_err_d;
  logic                timeout_expire;
  logic                grant_if;

`ifdef BUS_ARB_TIMEOUT_EN
  logic timer_en;
  assign timer_en = (state_q == BUS);

  bus_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!timer_en),
    .en    (timer_en),
    .expire(timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // IF only beats a pending MEM request once MEM has been granted STARVE_MAX times in a row.
  assign grant_if = if_req && (!mem_req || (starve_q == STARVE_W'(STARVE_MAX)));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          bus_req_d = 1'b1;
          state_d   = BUS;
          if (grant_if) begin
            owner_d     = OWN_IF;
            bus_rw_d    = 1'b0;
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_MEM;
            bus_rw_d    = mem_rw;
            bus_addr_d  = mem_addr;
            bus_wdata_d = mem_wdata;
            if (if_req && (starve_q != '1)) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end
        end
      end

      BUS: begin
        if (bus_ack || timeout_expire) begin
          bus_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_ack ? bus_rdata : ABORT_DATA;
          end else begin
            mem_ack_d = 1'b1;
            if (!bus_ack) begin
              mem_rdata_d = ABORT_DATA;
            end else if (bus_rw_q != RW_WRITE) begin
              mem_rdata_d = bus_rdata;
            end
          end
          if (!bus_ack) begin
            bus_err_d = 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_rw    = bus_rw_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu55_bus_arbiter.sv
// Self-checking bench for cpu55_bus_arbiter: directed scenarios plus randomized
// traffic against a transaction-level arbitration model.
module tb_cpu55_bus_arbiter;

  localparam int unsigned STARVE_MAX  = 4;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_rw, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_ack, mem_ack, bus_req, bus_rw, bus_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned starve_m = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_mem_rd = '0;
  int unsigned bus_rises = 0;
  logic        bus_req_prev = 1'b0;

  cpu55_bus_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .mem_req  (mem_req),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .bus_req  (bus_req),
    .bus_rw   (bus_rw),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_req === 1'b1 && bus_req_prev !== 1'b1) bus_rises = bus_rises + 1;
    bus_req_prev = bus_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: the model predicts the winner from the pending
  // requests and the MEM-streak count, then the bench plays the bus controller.
  task automatic txn(input int unsigned lat, input logic [31:0] rd, input bit keep,
                     output bit got_mem);
    bit own_mem;
    own_mem = mem_req && !(if_req && starve_m == STARVE_MAX);
    if (own_mem) begin
      if (if_req && starve_m < 15) starve_m++;
    end else begin
      starve_m = 0;
    end
    tick();
    chk("bus_req_rise", {31'd0, bus_req}, 32'd1);
    chk("bus_rw", {31'd0, bus_rw}, {31'd0, own_mem ? mem_rw : 1'b0});
    chk("bus_addr", bus_addr, own_mem ? mem_addr : if_addr);
    if (own_mem && mem_rw) chk("bus_wdata", bus_wdata, mem_wdata);
    for (int unsigned i = 0; i < lat; i++) begin
      tick();
      chk("bus_req_hold", {31'd0, bus_req}, 32'd1);
      chk("ack_early", {30'd0, if_ack, mem_ack}, 32'd0);
    end
    bus_ack = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    if (own_mem) begin
      if (!mem_rw) exp_mem_rd = rd;
    end else begin
      exp_if_rd = rd;
    end
    got_mem = mem_ack;
    chk("bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk("if_ack", {31'd0, if_ack}, {31'd0, !own_mem});
    chk("mem_ack", {31'd0, mem_ack}, {31'd0, own_mem});
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("mem_rdata", mem_rdata, exp_mem_rd);
    if (!keep) begin
      if (own_mem) mem_req = 1'b0;
      else if_req = 1'b0;
    end
    tick();
    chk("ack_pulse_end", {30'd0, if_ack, mem_ack}, 32'd0);
  endtask

  initial begin
    bit g;
    int unsigned r0;
    rst = 1'b0;
    if_req = 0; mem_req = 0; mem_rw = 0; bus_ack = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
    tick();
    tick();
    chk("rst_outputs", {if_ack, mem_ack, bus_req, bus_rw, bus_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Single fetch, bus_ack in the second BUS cycle.
    if_addr = 32'h0000_0040;
    if_req = 1'b1;
    txn(1, 32'h1234_5678, 0, g);
    chk("t1_owner_if", {31'd0, g}, 32'd0);

    // Simultaneous MEM write and IF read: MEM first, then IF.
    mem_rw = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hCAFE_F00D; mem_req = 1'b1;
    if_addr = 32'h0000_0080; if_req = 1'b1;
    txn(0, 32'h5555_AAAA, 0, g);
    chk("t2_first_mem", {31'd0, g}, 32'd1);
    txn(0, 32'h0BAD_F00D, 0, g);
    chk("t2_then_if", {31'd0, g}, 32'd0);

    // Request high during its own ack must not be issued twice.
    r0 = bus_rises;
    if_addr = 32'h0000_00C0; if_req = 1'b1;
    txn(0, 32'h7777_0001, 0, g);
    repeat (3) tick();
    chk("no_double_issue", bus_rises - r0, 32'd1);
    chk("idle_bus_req", {31'd0, bus_req}, 32'd0);

    // Continuous contention: MEM x4, IF, MEM x4, IF.
    mem_rw = 1'b0; mem_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_addr = $urandom; if_addr = $urandom;
      txn($urandom_range(0, 2), $urandom, 1, g);
      chk("starve_order", {31'd0, g}, (i % 5 == 4) ? 32'd0 : 32'd1);
    end
    mem_req = 1'b0; if_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of a BUS state.
    if_addr = 32'h0000_0200; if_req = 1'b1;
    tick();
    chk("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_outputs", {if_ack, mem_ack, bus_req, bus_err}, 32'd0);
    chk("async_rst_addr", bus_addr, 32'd0);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    starve_m = 0; exp_if_rd = '0; exp_mem_rd = '0;
    tick();
    chk("post_rst_idle", {31'd0, bus_req}, 32'd0);
    if_addr = 32'h0000_0300; if_req = 1'b1;
    txn(2, 32'h89AB_CDEF, 0, g);
    chk("post_rst_owner_if", {31'd0, g}, 32'd0);

    // Randomized mixed traffic.
    for (int i = 0; i < 40; i++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_addr = $urandom; if_req = 1'b1;
      end
      if (!mem_req && ($urandom_range(0, 1) == 1 || !if_req)) begin
        mem_rw = $urandom_range(0, 1) == 1; mem_addr = $urandom; mem_wdata = $urandom;
        mem_req = 1'b1;
      end
      txn($urandom_range(0, 3), $urandom, 0, g);
    end
    if (if_req || mem_req) txn(0, $urandom, 0, g);
    if (if_req || mem_req) txn(0, $urandom, 0, g);
    chk("bus_err_clear", {31'd0, bus_err}, 32'd0);

`ifdef BUS_ARB_TIMEOUT_EN
    // Abort after TIMEOUT_CYC BUS cycles with no bus_ack.
    mem_rw = 1'b0; mem_addr = 32'h400; mem_req = 1'b1;
    tick();
    chk("to_bus_req", {31'd0, bus_req}, 32'd1);
    for (int unsigned i = 1; i < TIMEOUT_CYC; i++) begin
      tick();
      chk("to_wait", {30'd0, bus_req, mem_ack}, 32'd2);
    end
    tick();
    chk("to_mem_ack", {31'd0, mem_ack}, 32'd1);
    chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
    mem_req = 1'b0;
    repeat (3) tick();
    chk("to_err_sticky", {31'd0, bus_err}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    starve_m = 0; exp_if_rd = '0; exp_mem_rd = '0;
    tick();
    chk("to_err_rst", {31'd0, bus_err}, 32'd0);
    // bus_ack in the limit cycle wins over the timeout.
    mem_addr = 32'h404; mem_req = 1'b1;
    txn(TIMEOUT_CYC - 1, 32'h0102_0304, 0, g);
    chk("to_ack_wins_err", {31'd0, bus_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu55_bus_arbiter.md
# cpu55_bus_arbiter

Arbitrates the CPU's single external bus-controller port between the instruction-fetch stage (read-only) and the memory stage (read/write) of the cpu55 pipeline. Each requester uses a request/acknowledge handshake. The arbiter registers the winning request onto the bus, waits for the bus controller's acknowledge, and returns read data with a one-cycle ack pulse. Fixed priority favours the memory stage, with a starvation guard that guarantees forward progress for fetch.

## Interface
- STARVE_MAX, 4: consecutive MEM grants while if_req is pending before IF is forced to win; legal range 1..15.
- TIMEOUT_CYC, 255: bus-wait cycles before abort; legal range 2..1023; used only with BUS_ARB_TIMEOUT_EN.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, **asynchronous, active-low**.
- if_req  in  1  fetch read request; held high until if_ack.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetch read data; valid when if_ack is high.
- if_ack  out  1  one-cycle completion pulse to fetch.
- mem_req  in  1  memory-stage request; held high until mem_ack.
- mem_rw  in  1  1 = write, 0 = read.
- mem_addr, mem_wdata  in  32 each  stable while mem_req is high.
- mem_rdata  out  32  memory read data; valid when mem_ack is high.
- mem_ack  out  1  one-cycle completion pulse to memory stage.
- bus_req  out  1  transaction valid toward the bus controller.
- bus_rw, bus_addr, bus_wdata  out  1/32/32  registered; constant while bus_req is high.
- bus_rdata  in  32  sampled when bus_ack is high.
- bus_ack  in  1  bus controller completion; meaningful only while bus_req is high.
- bus_err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if any request is pending, pick a winner, latch owner/rw/addr/wdata into bus registers, assert bus_req, and go to BUS. A write from IF is impossible; IF transactions force bus_rw = 0.
- BUS: hold bus_req. On bus_ack, capture bus_rdata into the owner's rdata register, drop bus_req, pulse the owner's ack, and go to RESP.
- RESP: single turnaround cycle. All requests are ignored this cycle, so a request still high during its own ack cannot be double-issued. Then go to IDLE.
- Priority: MEM wins over IF, except when starve_cnt == STARVE_MAX; then IF wins.
- starve_cnt is 4 bits.
  - Increments (saturating) on each MEM grant while if_req is high.
  - Clears on any IF grant.
- Non-owner rdata holds its last value. For write transactions, mem_rdata holds its prior value.
- Reset (any time, including mid-transaction) clears immediately:
  - state to IDLE;
  - all outputs to 0;
  - starve_cnt and the timeout counter to 0;
  - bus_err to 0.
- After reset, the bus controller must tolerate an abandoned bus_req.

## Timing
- Request sampled in IDLE at cycle N; bus_req rises at N+1.
- bus_ack is accepted at the earliest in cycle N+1.
- Requester ack and rdata appear at (bus_ack cycle)+1 and last exactly one cycle.
- Minimum turnaround per transaction is 3 cycles (IDLE, BUS, RESP) with zero-wait bus_ack.
- Back-to-back same-requester throughput is 1 transaction per 3 cycles.
- A simultaneous if_req and mem_req in IDLE is resolved in the same cycle; the loser waits, with no lost request.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - A 10-bit counter runs in the BUS state.
  - When TIMEOUT_CYC cycles elapse without bus_ack, the arbiter drops bus_req, pulses the owner's ack with rdata = 32'hDEAD_BEEF, sets bus_err, and goes to RESP.
  - bus_err stays set until reset.
  - If bus_ack arrives in the same cycle the limit is reached, bus_ack wins and bus_err is not set.
- BUS_ARB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; bus_err is tied to 0.

## Structure
- Package cpu55_bus_pkg holds:
  - state enum (IDLE/BUS/RESP);
  - owner encoding (OWN_IF = 0, OWN_MEM = 1);
  - RW_WRITE = 1'b1;
  - ABORT_DATA = 32'hDEAD_BEEF.
- One sub-module, bus_arb_timer: the timeout counter with clear, enable, and expire outputs. It is instantiated only under BUS_ARB_TIMEOUT_EN.

## Test plan
- if_req with addr 0x0000_0040 and bus_ack at 2nd BUS cycle, bus_rdata = 0x1234_5678: bus_req high for 2 cycles, bus_rw = 0, then if_ack pulses for 1 cycle with if_rdata = 0x1234_5678.
- mem_req write (addr 0x100, wdata 0xCAFE_F00D) with if_req rising in the same cycle: MEM is granted first (bus_rw = 1, bus_wdata = 0xCAFE_F00D), and IF is granted on the next IDLE.
- mem_req held continuously with if_req held high and STARVE_MAX = 4: grant order is MEM×4, IF, MEM×4, IF; starve_cnt never exceeds 4.
- Requester keeps req high during its ack cycle: exactly one bus transaction is issued, not two.
- rst pulled low while in the BUS state: bus_req, acks, and bus_err drop asynchronously. After release, the FSM is in IDLE and a new if_req completes normally.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, bus_ack never asserted: after 8 BUS cycles, mem_ack pulses with mem_rdata = 0xDEAD_BEEF and bus_err = 1 (sticky). With bus_ack on cycle 8 instead, normal completion and bus_err = 0.
